// File: rtl/image_pkg.sv
// Shared image geometry and writer types for the VGA display path.
// The VGA controller imports the same constants so both sides agree on RAM layout.
package image_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int ADDR_W = $clog2(IMG_W) + $clog2(IMG_H);
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    WRITE
  } writer_state_t;

  typedef logic [ADDR_W-1:0] img_addr_t;

endpackage

// File: rtl/img_xy_counter.sv
// Column/row position counter for the image writer; produces the row-major
// RAM address {row, col} and flags the last pixel of a frame.
module img_xy_counter
  import image_pkg::*;
#(
  parameter int IMG_W  = image_pkg::IMG_W,
  parameter int IMG_H  = image_pkg::IMG_H,
  parameter int ADDR_W = image_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              origin
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;
  logic             row_end;

  assign col_end = (col == COL_W'(IMG_W - 1));
  assign row_end = (row == ROW_W'(IMG_H - 1));

  // load parks the counter on (row 0, col 1): the pixel at (0,0) is the one
  // being written in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= COL_W'(1);
      row <= '0;
    end else if (inc) begin
      col <= col + 1'b1;
      if (col_end) begin
        row <= row + 1'b1;
      end
    end
  end

  assign addr   = {row, col};
  assign last   = col_end && row_end;
  assign origin = (col == '0) && (row == '0);

endmodule

// File: rtl/image_ram_writer.sv
// Raster pixel stream to image RAM writer with frame tracking and SOF resync.
// Optional WRITER_VBLANK_SYNC_EN: hold a start-of-frame beat until vga_vblank.
module image_ram_writer
  import image_pkg::*;
#(
  parameter int IMG_W  = image_pkg::IMG_W,
  parameter int IMG_H  = image_pkg::IMG_H,
  parameter int ADDR_W = image_pkg::ADDR_W,
  parameter int DATA_W = image_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              px_valid,
  input  logic              px_sof,
  input  logic [DATA_W-1:0] px_data,
  output logic              px_ready,
  input  logic              vga_vblank,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WE,
  output logic              frame_done,
  output logic              sync_err,
  output logic [7:0]        frame_cnt
);

  writer_state_t     state;
  logic              seek_ready;
  logic              accept;
  logic              resync;
  logic              xy_clr;
  logic              xy_load;
  logic              xy_inc;
  logic [ADDR_W-1:0] xy_addr;
  logic              xy_last;
  logic              xy_origin;

`ifdef WRITER_VBLANK_SYNC_EN
  // Only a start-of-frame beat waits for blanking; junk beats drain freely.
  assign seek_ready = !(px_valid && px_sof && !vga_vblank);
`else
  logic unused_vblank;
  assign unused_vblank = vga_vblank;
  assign seek_ready    = 1'b1;
`endif

  // wr_en gates ready combinationally so a disable takes effect this cycle.
  always_comb begin
    px_ready = 1'b0;
    if (!rst && wr_en) begin
      case (state)
        SEEK:    px_ready = seek_ready;
        WRITE:   px_ready = 1'b1;
        default: px_ready = 1'b0;
      endcase
    end
  end

  assign accept = px_valid && px_ready;
  assign resync = (state == WRITE) && accept && px_sof && !xy_origin;

  always_comb begin
    xy_clr  = !wr_en;
    xy_load = 1'b0;
    xy_inc  = 1'b0;
    if (accept) begin
      case (state)
        SEEK: xy_load = px_sof;
        WRITE: begin
          if (resync) begin
            xy_load = 1'b1;
          end else if (xy_last) begin
            xy_clr = 1'b1;
          end else begin
            xy_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  img_xy_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_xy (
    .clk    (clk),
    .rst    (rst),
    .clr    (xy_clr),
    .load   (xy_load),
    .inc    (xy_inc),
    .addr   (xy_addr),
    .last   (xy_last),
    .origin (xy_origin)
  );

  // Write port registers: the accepted beat appears on the RAM one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      RAM_WE     <= 1'b0;
      RAM_WADDR  <= '0;
      RAM_WDATA  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      RAM_WE     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (!wr_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SEEK;
          SEEK: begin
            if (accept && px_sof) begin
              RAM_WE    <= 1'b1;
              RAM_WADDR <= '0;
              RAM_WDATA <= px_data;
              state     <= WRITE;
            end
          end
          WRITE: begin
            if (accept) begin
              RAM_WE    <= 1'b1;
              RAM_WDATA <= px_data;
              if (resync) begin
                RAM_WADDR <= '0;
                sync_err  <= 1'b1;
              end else begin
                RAM_WADDR <= xy_addr;
                if (xy_last) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  state      <= SEEK;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_ram_writer.sv
// Scoreboard bench for image_ram_writer on a 256x4 image (address layout kept,
// frame shortened). Also exercises the WRITER_VBLANK_SYNC_EN build when defined.
module tb_image_ram_writer;

  localparam int TW   = 256;
  localparam int TH   = 4;
  localparam int TA   = 10;
  localparam int NPIX = TW * TH;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          px_valid;
  logic          px_sof;
  logic [7:0]    px_data;
  logic          px_ready;
  logic          vga_vblank;
  logic [TA-1:0] RAM_WADDR;
  logic [7:0]    RAM_WDATA;
  logic          RAM_WE;
  logic          frame_done;
  logic          sync_err;
  logic [7:0]    frame_cnt;

  image_ram_writer #(
    .IMG_W  (TW),
    .IMG_H  (TH),
    .ADDR_W (TA),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .px_valid   (px_valid),
    .px_sof     (px_sof),
    .px_data    (px_data),
    .px_ready   (px_ready),
    .vga_vblank (vga_vblank),
    .RAM_WADDR  (RAM_WADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_WE     (RAM_WE),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TA-1:0] addr;
    logic [7:0]    data;
    logic          done;
    logic          serr;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;
  bit  m_seek;
  int  m_row;
  int  m_col;
  int  m_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference writer: decides which accepted beats produce which RAM writes.
  task automatic model_accept(input logic sof, input logic [7:0] d);
    wr_t e;
    e.data = d;
    e.done = 1'b0;
    e.serr = 1'b0;
    e.addr = '0;
    if (m_seek) begin
      if (sof) begin
        exp_q.push_back(e);
        m_seek = 1'b0;
        m_row  = 0;
        m_col  = 1;
      end
    end else if (sof && !(m_row == 0 && m_col == 0)) begin
      e.serr = 1'b1;
      exp_q.push_back(e);
      m_row = 0;
      m_col = 1;
    end else begin
      e.addr = TA'(m_row * TW + m_col);
      e.done = (m_row == TH - 1) && (m_col == TW - 1);
      exp_q.push_back(e);
      if (e.done) begin
        m_frames++;
        m_seek = 1'b1;
        m_row  = 0;
        m_col  = 0;
      end else begin
        m_col++;
        if (m_col == TW) begin
          m_col = 0;
          m_row++;
        end
      end
    end
  endtask

  task automatic model_clear();
    m_seek = 1'b1;
    m_row  = 0;
    m_col  = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (RAM_WE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(RAM_WE), 32'd0);
        end else begin
          got_e = exp_q.pop_front();
          check("waddr", 32'(RAM_WADDR), 32'(got_e.addr));
          check("wdata", 32'(RAM_WDATA), 32'(got_e.data));
          check("frame_done", 32'(frame_done), 32'(got_e.done));
          check("sync_err", 32'(sync_err), 32'(got_e.serr));
        end
      end else begin
        check("stray_pulse", {30'd0, frame_done, sync_err}, 32'd0);
      end
    end
  end

  // Present one beat and hold it until the DUT is ready; returns before the accepting edge.
  task automatic send(input logic sof, input logic [7:0] d);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    px_valid = 1'b1;
    px_sof   = sof;
    px_data  = d;
    #1;
    while (!px_ready) begin
      if (waited > 200) begin
        check("ready_timeout", 32'(px_ready), 32'd1);
        px_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #2;
      waited++;
    end
    model_accept(sof, d);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    px_valid = 1'b0;
    px_sof   = 1'($urandom);
    px_data  = 8'($urandom);
  endtask

  task automatic send_frame(input int start, input int n, input int sof_idx, input bit gaps);
    for (int i = start; i < start + n; i++) begin
      if (gaps && $urandom_range(1) == 1) idle_cycle();
      send((i == 0) || (i == sof_idx), 8'(i));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_q", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b1;
    px_valid   = 1'b1;
    px_sof     = 1'b1;
    px_data    = 8'h11;
    vga_vblank = 1'b0;
    m_frames   = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(px_ready), 32'd0);
    check("rst_we", 32'(RAM_WE), 32'd0);
    check("rst_waddr", 32'(RAM_WADDR), 32'd0);
    check("rst_wdata", 32'(RAM_WDATA), 32'd0);
    check("rst_pulses", {30'd0, frame_done, sync_err}, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    px_valid = 1'b0;
    mon_en   = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(px_ready), 32'd0);

    // Full frame, back-to-back.
    send_frame(0, NPIX, -1, 1'b0);
    idle_cycle();
    drain();
    check("frame_cnt_t1", 32'(frame_cnt), 32'(m_frames));

    // Junk before sof, then sof with a one-cycle write latency check.
    for (int i = 0; i < 5; i++) send(1'b0, 8'(8'hA0 + i));
    send(1'b1, 8'd0);
    idle_cycle();
    @(negedge clk);
    check("sof_we_latency", 32'(RAM_WE), 32'd1);
    check("sof_addr", 32'(RAM_WADDR), 32'd0);
    send_frame(1, NPIX - 1, -1, 1'b0);
    idle_cycle();
    drain();
    check("frame_cnt_t2", 32'(frame_cnt), 32'(m_frames));

    // Random valid gaps over a whole frame.
    send_frame(0, NPIX, -1, 1'b1);
    idle_cycle();
    drain();
    check("frame_cnt_t3", 32'(frame_cnt), 32'(m_frames));

    // Early sof at beat 300 (row 1, col 44), then the restarted frame completes.
    send_frame(0, 301, 300, 1'b0);
    send_frame(1, NPIX - 1, -1, 1'b0);
    idle_cycle();
    drain();
    check("frame_cnt_t4", 32'(frame_cnt), 32'(m_frames));

    // Disable mid-frame: partial frame abandoned, restart at address 0.
    send_frame(0, 1000, -1, 1'b0);
    idle_cycle();
    wr_en    = 1'b0;
    px_valid = 1'b1;
    px_sof   = 1'b1;
    model_clear();
    #1;
    check("dis_ready_comb", 32'(px_ready), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("dis_ready", 32'(px_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    px_valid = 1'b0;
    wr_en    = 1'b1;
    drain();
    check("frame_cnt_partial", 32'(frame_cnt), 32'(m_frames));
    send_frame(0, NPIX, -1, 1'b0);
    idle_cycle();
    drain();
    check("frame_cnt_t5", 32'(frame_cnt), 32'(m_frames));

    // Start-of-frame while not in vertical blanking.
    @(posedge clk);
    #1;
    vga_vblank = 1'b0;
    px_valid   = 1'b1;
    px_sof     = 1'b1;
    px_data    = 8'h5A;
`ifdef WRITER_VBLANK_SYNC_EN
    repeat (20) begin
      @(negedge clk);
      check("vb_stall_ready", 32'(px_ready), 32'd0);
    end
    vga_vblank = 1'b1;
    #1;
    check("vb_release_ready", 32'(px_ready), 32'd1);
`else
    #1;
    check("sof_ready_no_vb", 32'(px_ready), 32'd1);
`endif
    model_accept(1'b1, 8'h5A);
    idle_cycle();
    @(negedge clk);
    check("vb_we", 32'(RAM_WE), 32'd1);
    check("vb_addr", 32'(RAM_WADDR), 32'd0);
    vga_vblank = 1'b0;

    // Reset mid-frame: beat presented during reset is not written.
    send_frame(1, 10, -1, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    px_valid = 1'b1;
    px_sof   = 1'b1;
    px_data  = 8'hEE;
    model_clear();
    m_frames = 0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    px_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 32'(RAM_WE), 32'd0);
    check("rst_mid_frame_cnt", 32'(frame_cnt), 32'(m_frames));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
